simon_response_checker: RTL and testbench

- Player-side counterpart of the Simon playback engine. Simon emits the sequence; this block receives the player's repetition and judges it.
- Stores the sequence appended by the generator, one 2-bit colour per round.
- On start, compares each player press (num/pressed from the button interpreter) against the stored entry.
- Reports round success, mistake, or timeout. Sits between the button interpreter and the Simon controller; drives game_over to the display.

---
 rtl/simon_pkg.sv | 19 +
 rtl/press_sync_edge.sv | 39 +++
 rtl/simon_response_checker.sv | 122 ++++++++++++
 tb/tb_simon_response_checker.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game blocks: colour width, colour codes and
// the response-checker state encoding.
package simon_pkg;

  localparam int unsigned NUM_W = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2,
    FAIL         = 2'd3
  } state_t;

  localparam logic [NUM_W-1:0] GREEN  = 2'd0;
  localparam logic [NUM_W-1:0] RED    = 2'd1;
  localparam logic [NUM_W-1:0] YELLOW = 2'd2;
  localparam logic [NUM_W-1:0] BLUE   = 2'd3;

endpackage

// File: rtl/press_sync_edge.sv
// Brings an asynchronous button level and its colour code into the clk domain
// and produces single-cycle rise/fall pulses on the synchronized level.
module press_sync_edge #(
  parameter int unsigned NUM_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pressed,
  input  logic [NUM_W-1:0] num,
  output logic             rise,
  output logic             fall,
  output logic [NUM_W-1:0] num_sync
);

  logic             pressed_s1, pressed_s2, pressed_prev;
  logic [NUM_W-1:0] num_s1, num_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pressed_s1   <= 1'b0;
      pressed_s2   <= 1'b0;
      pressed_prev <= 1'b0;
      num_s1       <= '0;
      num_s2       <= '0;
    end else begin
      pressed_s1   <= pressed;
      pressed_s2   <= pressed_s1;
      pressed_prev <= pressed_s2;
      num_s1       <= num;
      num_s2       <= num_s1;
    end
  end

  // Colour travels through the same depth as the level, so it is valid alongside rise.
  assign rise     = pressed_s2 & ~pressed_prev;
  assign fall     = ~pressed_s2 & pressed_prev;
  assign num_sync = num_s2;

endmodule

// File: rtl/simon_response_checker.sv
// Stores the generated colour sequence and judges the player's repetition,
// reporting round completion, a wrong colour, or a press timeout.
module simon_response_checker
  import simon_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  localparam int unsigned LW            = $clog2(MAX_LEN) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             append_valid,
  input  logic [NUM_W-1:0] append_num,
  input  logic             start,
  input  logic [NUM_W-1:0] player_num,
  input  logic             player_pressed,
  output logic [LW-1:0]    seq_len,
  output logic             full,
  output logic             checking,
  output logic [LW-1:0]    progress,
  output logic             round_ok,
  output logic             game_over
);

  localparam int unsigned IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [TW-1:0]    timer;
  logic [NUM_W-1:0] mem [MAX_LEN];
  logic             rise, fall;
  logic [NUM_W-1:0] num_sync;
  logic [NUM_W-1:0] expected;
  logic [LW-1:0]    progress_next;
  logic             append_ok, start_ok;

  press_sync_edge #(.NUM_W(NUM_W)) u_sync (
    .clk      (clk),
    .reset    (reset),
    .pressed  (player_pressed),
    .num      (player_num),
    .rise     (rise),
    .fall     (fall),
    .num_sync (num_sync)
  );

  assign full          = (seq_len == LW'(MAX_LEN));
  assign checking      = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign expected      = mem[progress[IW-1:0]];
  assign progress_next = progress + LW'(1);
  assign append_ok     = !clear && append_valid && (state == IDLE) && !full && !game_over;
  assign start_ok      = !clear && start && (state == IDLE) && (seq_len != '0) && !game_over;

  always_ff @(posedge clk) begin
    if (append_ok) mem[seq_len[IW-1:0]] <= append_num;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      seq_len   <= '0;
      progress  <= '0;
      timer     <= '0;
      round_ok  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      round_ok <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        seq_len   <= '0;
        progress  <= '0;
        timer     <= '0;
        game_over <= 1'b0;
      end else begin
        if (append_ok) seq_len <= seq_len + LW'(1);
        case (state)
          IDLE: begin
            if (start_ok) begin
              state    <= WAIT_PRESS;
              progress <= '0;
              timer    <= '0;
            end
          end
          WAIT_PRESS: begin
            // A rise is judged before the timeout so a last-cycle press still counts.
            if (rise) begin
              if (num_sync == expected) begin
                state <= WAIT_RELEASE;
                timer <= '0;
              end else begin
                game_over <= 1'b1;
                state     <= FAIL;
              end
            end else if (timer == TIMEOUT_LAST) begin
              game_over <= 1'b1;
              state     <= FAIL;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          WAIT_RELEASE: begin
            if (fall) begin
              progress <= progress_next;
              if (progress_next == seq_len) begin
                round_ok <= 1'b1;
                state    <= IDLE;
              end else begin
                state <= WAIT_PRESS;
                timer <= '0;
              end
            end
          end
          FAIL: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_simon_response_checker.sv
// Directed bench for simon_response_checker: stimulus pushes timed expected
// events into a queue that a negedge monitor pops and compares.
module tb_simon_response_checker;

  localparam int MAXL = 4;
  localparam int TOUT = 20;
  localparam int K_PROG  = 0;
  localparam int K_ROUND = 1;
  localparam int K_GO    = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       append_valid = 1'b0;
  logic [1:0] append_num = '0;
  logic       start = 1'b0;
  logic [1:0] player_num = '0;
  logic       player_pressed = 1'b0;
  logic [2:0] seq_len;
  logic       full;
  logic       checking;
  logic [2:0] progress;
  logic       round_ok;
  logic       game_over;

  simon_response_checker #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .clear          (clear),
    .append_valid   (append_valid),
    .append_num     (append_num),
    .start          (start),
    .player_num     (player_num),
    .player_pressed (player_pressed),
    .seq_len        (seq_len),
    .full           (full),
    .checking       (checking),
    .progress       (progress),
    .round_ok       (round_ok),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  cyc = 0;
  int  mprog = 0;
  int  mlen = 0;
  bit  mgo = 1'b0;
  logic [2:0] prev_prog = '0;
  logic       prev_go = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    q.push_back(e);
  endtask

  task automatic sb_check(input int kind, input int val);
    ev_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_event: got kind=%0d val=%0d cyc=%0d, required no event", kind, val, cyc);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc) begin
        miscompares++;
        $display("FAIL event: got kind=%0d val=%0d cyc=%0d, required kind=%0d val=%0d cyc=%0d",
                 kind, val, cyc, e.kind, e.val, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (progress !== prev_prog) sb_check(K_PROG, int'(progress));
      if (round_ok) sb_check(K_ROUND, int'(seq_len));
      if (game_over && !prev_go) sb_check(K_GO, int'(progress));
    end
    prev_prog <= progress;
    prev_go   <= game_over;
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic app(input logic [1:0] c);
    append_valid = 1'b1;
    append_num   = c;
    tick(1);
    append_valid = 1'b0;
    if (!mgo && mlen < MAXL) mlen++;
  endtask

  task automatic start_round(output int s);
    s = cyc;
    start = 1'b1;
    tick(1);
    start = 1'b0;
    if (mprog != 0) push(K_PROG, 0, s + 1);
    mprog = 0;
  endtask

  task automatic clr();
    int p;
    p = cyc;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    if (mprog != 0) push(K_PROG, 0, p + 1);
    mprog = 0;
    mlen  = 0;
    mgo   = 1'b0;
  endtask

  task automatic press_ok(input logic [1:0] c, input int hold, input bit last);
    int r;
    player_num     = c;
    player_pressed = 1'b1;
    tick(hold);
    player_pressed = 1'b0;
    r = cyc;
    mprog++;
    push(K_PROG, mprog, r + 3);
    if (last) push(K_ROUND, mlen, r + 3);
    tick(2);
  endtask

  task automatic press_bad(input logic [1:0] c);
    player_num     = c;
    player_pressed = 1'b1;
    push(K_GO, mprog, cyc + 3);
    mgo = 1'b1;
    tick(3);
    player_pressed = 1'b0;
    tick(3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    int r;

    tick(3);
    chk("rst_seq_len", int'(seq_len), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_checking", int'(checking), 0);
    chk("rst_progress", int'(progress), 0);
    chk("rst_round_ok", int'(round_ok), 0);
    chk("rst_game_over", int'(game_over), 0);
    reset = 1'b1;
    tick(2);

    // Asynchronous reset while waiting for the first press
    app(2'd2); app(2'd0); app(2'd3);
    start_round(s);
    tick(3);
    chk("t1_checking_before", int'(checking), 1);
    #2 reset = 1'b0;
    #1;
    chk("t1_async_seq_len", int'(seq_len), 0);
    chk("t1_async_checking", int'(checking), 0);
    chk("t1_async_game_over", int'(game_over), 0);
    mlen = 0; mprog = 0;
    tick(2);
    reset = 1'b1;
    tick(2);

    // Full round of three presses
    app(2'd2); app(2'd0); app(2'd3);
    chk("t2_seq_len", int'(seq_len), 3);
    start_round(s);
    chk("t2_checking", int'(checking), 1);
    press_ok(2'd2, 5, 1'b0);
    press_ok(2'd0, 5, 1'b0);
    press_ok(2'd3, 5, 1'b1);
    tick(4);
    chk("t2_idle", int'(checking), 0);
    chk("t2_progress", int'(progress), 3);

    // Colour change, start and append while the button is held
    clr();
    app(2'd3); app(2'd0);
    start_round(s);
    player_num     = 2'd3;
    player_pressed = 1'b1;
    tick(4);
    chk("t6_held_checking", int'(checking), 1);
    player_num   = 2'd1;
    start        = 1'b1;
    append_valid = 1'b1;
    append_num   = 2'd2;
    tick(1);
    start        = 1'b0;
    append_valid = 1'b0;
    tick(2);
    chk("t6_seq_len", int'(seq_len), 2);
    chk("t6_progress_held", int'(progress), 0);
    player_pressed = 1'b0;
    r = cyc;
    mprog = 1;
    push(K_PROG, 1, r + 3);
    tick(2);
    press_ok(2'd0, 5, 1'b1);
    tick(4);
    chk("t6_seq_len_end", int'(seq_len), 2);

    // Wrong colour on the second press
    clr();
    app(2'd1); app(2'd1);
    start_round(s);
    press_ok(2'd1, 3, 1'b0);
    press_bad(2'd2);
    chk("t3_game_over", int'(game_over), 1);
    chk("t3_progress", int'(progress), 1);
    start        = 1'b1;
    append_valid = 1'b1;
    append_num   = 2'd0;
    tick(1);
    start        = 1'b0;
    append_valid = 1'b0;
    tick(2);
    chk("t3_seq_len_locked", int'(seq_len), 2);
    chk("t3_checking_fail", int'(checking), 0);
    chk("t3_game_over_sticky", int'(game_over), 1);
    clr();
    chk("t3_clear_game_over", int'(game_over), 0);
    chk("t3_clear_seq_len", int'(seq_len), 0);

    // Timeout, then a press landing exactly on the timeout cycle
    app(2'd0);
    start_round(s);
    push(K_GO, 0, s + 1 + TOUT);
    mgo = 1'b1;
    tick(TOUT + 4);
    chk("t4_timeout_game_over", int'(game_over), 1);
    clr();
    app(2'd0);
    start_round(s);
    tick(s + TOUT - 2 - cyc);
    player_num     = 2'd0;
    player_pressed = 1'b1;
    tick(3);
    player_pressed = 1'b0;
    r = cyc;
    mprog = 1;
    push(K_PROG, 1, r + 3);
    push(K_ROUND, 1, r + 3);
    tick(5);
    chk("t4_edge_no_game_over", int'(game_over), 0);
    chk("t4_edge_idle", int'(checking), 0);

    // Saturation at MAX_LEN and clear
    clr();
    app(2'd0); app(2'd1); app(2'd2); app(2'd3); app(2'd0);
    chk("t5_seq_len_sat", int'(seq_len), MAXL);
    chk("t5_full", int'(full), 1);
    start_round(s);
    press_ok(2'd0, 3, 1'b0);
    press_ok(2'd1, 3, 1'b0);
    press_ok(2'd2, 3, 1'b0);
    press_ok(2'd3, 3, 1'b1);
    tick(4);
    clr();
    chk("t5_clear_seq_len", int'(seq_len), 0);
    chk("t5_clear_full", int'(full), 0);

    tick(5);
    while (q.size() > 0) begin
      ev_t e;
      e = q.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL missing_event: got none, required kind=%0d val=%0d cyc=%0d", e.kind, e.val, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
